gf2m_ds_mul: RTL and testbench

//   Parametrised digit-serial GF(2^M) multiplier, polynomial basis, MSB-first.

---
 rtl/gf2m_ds_mul_if.sv | 21 ++
 rtl/gf2m_ds_mul.sv | 108 ++++++++++
 tb/tb_gf2m_ds_mul.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2m_ds_mul_if.sv
// Start/done handshake bundle for the digit-serial GF(2^M) multiplier.
interface gf2m_ds_mul_if #(
    parameter int M = 239
);
    logic         start;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         busy;
    logic         done;
    logic [M-1:0] z;

    modport master (
        output start, a, b,
        input  busy, done, z
    );

    modport slave (
        input  start, a, b,
        output busy, done, z
    );
endinterface

// File: rtl/gf2m_ds_mul.sv
// Digit-serial MSB-first GF(2^M) polynomial-basis multiplier, z = a*b mod f.
// One D-bit digit of b per cycle, single-step reduction by the tail POLY.
module gf2m_ds_mul #(
    parameter int           M    = 239,
    parameter int           D    = 8,
    parameter logic [M-1:0] POLY = (M'(1) << 158) | M'(1)
) (
    input logic          clk,
    input logic          rst_n,
    input logic          clr,
    gf2m_ds_mul_if.slave bus
);
    localparam int N  = (M + D - 1) / D;
    localparam int NW = N * D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [M-1:0]   areg;
    logic [NW-1:0]  breg;
    logic [M-1:0]   acc;
    logic [M-1:0]   acc_nx;
    logic [M-1:0]   zq;
    logic [CW-1:0]  cnt;
    logic           fin;
    logic           go;
    logic [D-1:0]   dig;
    logic [D-1:0]   hi;
    logic [M+D-1:0] t;

    assign go  = bus.start && !clr && (state == IDLE || state == DONE);
    assign dig = breg[NW-1 -: D];

    // Both partial terms share one fold: the overflow above x^M is < D bits
    // wide, so hi*POLY stays below degree M when D <= M - deg(POLY).
    always_comb begin
        t = {acc, {D{1'b0}}};
        for (int i = 0; i < D; i++) begin
            if (dig[i]) t = t ^ ({{D{1'b0}}, areg} << i);
        end
        hi     = t[M+D-1 -: D];
        acc_nx = t[M-1:0];
        for (int i = 0; i < D; i++) begin
            if (hi[i]) acc_nx = acc_nx ^ (POLY << i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clr) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_n = CALC;
                CALC:    if (fin) state_n = DONE;
                DONE:    state_n = bus.start ? CALC : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // fin marks the extra CALC cycle that publishes acc after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg <= '0;
            breg <= '0;
            acc  <= '0;
            zq   <= '0;
            cnt  <= '0;
            fin  <= 1'b0;
        end else if (clr) begin
            acc  <= '0;
            zq   <= '0;
            cnt  <= '0;
            fin  <= 1'b0;
        end else if (go) begin
            areg <= bus.a;
            breg <= NW'(bus.b);
            acc  <= '0;
            cnt  <= CW'(N - 1);
            fin  <= 1'b0;
        end else if (state == CALC) begin
            if (fin) begin
                zq <= acc;
            end else begin
                acc  <= acc_nx;
                breg <= breg << D;
                if (cnt == '0) fin <= 1'b1;
                else           cnt <= cnt - CW'(1);
            end
        end
    end

    assign bus.busy = (state == CALC);
    assign bus.done = (state == DONE);
    assign bus.z    = zq;
endmodule

// File: tb/tb_gf2m_ds_mul.sv
// Directed and reference-model bench for gf2m_ds_mul over four configurations.
module tb_gf2m_ds_mul;
    logic clk;
    logic rst_n;
    logic clr;
    int   checks;
    int   errors;

    localparam logic [238:0] P239 = (239'(1) << 158) | 239'(1);
    localparam logic [238:0] P163 = 239'h0C9;

    gf2m_ds_mul_if #(.M(239)) if0 ();
    gf2m_ds_mul_if #(.M(239)) if1 ();
    gf2m_ds_mul_if #(.M(239)) if2 ();
    gf2m_ds_mul_if #(.M(163)) if3 ();

    gf2m_ds_mul #(.M(239), .D(8)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0)
    );
    gf2m_ds_mul #(.M(239), .D(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1)
    );
    gf2m_ds_mul #(.M(239), .D(16)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2)
    );
    gf2m_ds_mul #(.M(163), .D(8), .POLY(163'hC9)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [238:0] got,
                         input logic [238:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [238:0] msk(input int m);
        logic [238:0] r;
        for (int i = 0; i < 239; i++) r[i] = (i < m);
        return r;
    endfunction

    // Bit-serial shift-and-add: r = r*x mod f, then add a for each set bit of b.
    function automatic logic [238:0] ref_mul(input logic [238:0] a, b, poly,
                                             input int m);
        logic [238:0] r;
        logic         c;
        r = '0;
        for (int i = 238; i >= 0; i--) begin
            if (i < m) begin
                c = r[m-1];
                r = (r << 1) & msk(m);
                if (c) r = r ^ poly;
                if (b[i]) r = r ^ a;
            end
        end
        return r;
    endfunction

    function automatic logic [238:0] rnd(input int m);
        logic [238:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[206:0], 32'($urandom)};
        return r & msk(m);
    endfunction

    task automatic set_in(input int sel, input logic s,
                          input logic [238:0] a, b);
        case (sel)
            0: begin if0.start = s; if0.a = a; if0.b = b; end
            1: begin if1.start = s; if1.a = a; if1.b = b; end
            2: begin if2.start = s; if2.a = a; if2.b = b; end
            default: begin
                if3.start = s; if3.a = a[162:0]; if3.b = b[162:0];
            end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if0.done;
            1: return if1.done;
            2: return if2.done;
            default: return if3.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return if0.busy;
            1: return if1.busy;
            2: return if2.busy;
            default: return if3.busy;
        endcase
    endfunction

    function automatic logic [238:0] get_z(input int sel);
        case (sel)
            0: return if0.z;
            1: return if1.z;
            2: return if2.z;
            default: return 239'(if3.z);
        endcase
    endfunction

    task automatic mul(input int sel, input logic [238:0] a, b,
                       output logic [238:0] z, output int lat,
                       output logic bz);
        @(negedge clk);
        set_in(sel, 1'b1, a, b);
        @(posedge clk);
        #1 set_in(sel, 1'b0, a, b);
        lat = 0;
        bz  = 1'b1;
        while (!get_done(sel) && lat < 600) begin
            if (!get_busy(sel)) bz = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        z = get_z(sel);
    endtask

    initial begin
        logic [238:0] z;
        logic [238:0] ea;
        logic [238:0] eb;
        logic         bz;
        int           lat;
        int           dn;
        int           first;
        int           nops;
        int           mm;
        int           lexp [4];
        logic [238:0] pp   [4];

        checks = 0;
        errors = 0;
        clr    = 1'b0;
        rst_n  = 1'b0;
        for (int s = 0; s < 4; s++) set_in(s, 1'b0, '0, '0);
        #12;
        check("rst_busy", 239'(if0.busy), 239'(0));
        check("rst_done", 239'(if0.done), 239'(0));
        check("rst_z", if0.z, '0);
        @(negedge clk);
        rst_n = 1'b1;

        mul(0, 239'd1, 239'd1, z, lat, bz);
        check("t1_z", z, 239'd1);
        check("t1_lat", 239'(lat), 239'd31);
        check("t1_busy_in", 239'(bz), 239'd1);
        check("t1_busy_dn", 239'(if0.busy), 239'd0);
        @(posedge clk);
        #1 check("t1_pulse", 239'(if0.done), 239'd0);

        mul(0, 239'd2, 239'(1) << 238, z, lat, bz);
        check("t2_x239", z, P239);
        mul(0, 239'(1) << 238, 239'd2, z, lat, bz);
        check("t2_swap", z, P239);
        mul(0, 239'd3, 239'd3, z, lat, bz);
        check("sq_x1", z, 239'd5);
        mul(0, '0, 239'h1234, z, lat, bz);
        check("a_zero", z, '0);

        // busy start at cycle 5 must be ignored
        @(negedge clk);
        set_in(0, 1'b1, 239'd1 << 100, 239'd7);
        @(posedge clk);
        #1 set_in(0, 1'b0, 239'd1 << 100, 239'd7);
        dn    = 0;
        first = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) set_in(0, 1'b1, 239'd2, 239'(1) << 238);
            if (k == 6) set_in(0, 1'b0, 239'd2, 239'(1) << 238);
            @(posedge clk);
            #1;
            if (if0.done) begin
                dn++;
                if (first == 0) begin
                    first = k;
                    check("t3_z", if0.z, 239'd7 << 100);
                end
            end
        end
        check("t3_ndone", 239'(dn), 239'd1);
        check("t3_lat", 239'(first), 239'd31);

        // clr at cycle 10 aborts
        @(negedge clk);
        set_in(0, 1'b1, 239'd3, 239'd3);
        @(posedge clk);
        #1 set_in(0, 1'b0, 239'd3, 239'd3);
        repeat (10) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("t4_busy", 239'(if0.busy), 239'd0);
        check("t4_z", if0.z, '0);
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (if0.done) dn++;
        end
        check("t4_nodone", 239'(dn), 239'd0);

        mul(0, 239'hABCDEF, 239'd1, z, lat, bz);
        check("b_one", z, 239'hABCDEF);

        // async reset at cycle 12 of a new op
        @(negedge clk);
        set_in(0, 1'b1, 239'd3, 239'd3);
        @(posedge clk);
        #1 set_in(0, 1'b0, 239'd3, 239'd3);
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t4_rst_z", if0.z, '0);
        check("t4_rst_done", 239'(if0.done), 239'd0);
        check("t4_rst_busy", 239'(if0.busy), 239'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back start in DONE
        mul(0, 239'd1 << 120, 239'd1 << 119, z, lat, bz);
        check("t5_z1", z, P239);
        set_in(0, 1'b1, 239'd3, 239'd3);
        @(posedge clk);
        #1 set_in(0, 1'b0, 239'd3, 239'd3);
        lat = 0;
        while (!if0.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t5_lat", 239'(lat), 239'd31);
        check("t5_z2", if0.z, 239'd5);

        lexp = '{31, 240, 16, 22};
        pp   = '{P239, P239, P239, P163};
        for (int s = 1; s < 4; s++) begin
            mm = (s == 3) ? 163 : 239;
            mul(s, 239'd2, 239'(1) << (mm - 1), z, lat, bz);
            check($sformatf("cfg%0d_xm", s), z, pp[s]);
            check($sformatf("cfg%0d_lat", s), 239'(lat), 239'(lexp[s]));
            nops = (s == 1) ? 100 : 200;
            for (int n = 0; n < nops; n++) begin
                ea = rnd(mm);
                eb = rnd(mm);
                mul(s, ea, eb, z, lat, bz);
                check($sformatf("cfg%0d_rnd%0d", s, n), z,
                      ref_mul(ea, eb, pp[s], mm));
                if (lat != lexp[s])
                    check($sformatf("cfg%0d_tmo%0d", s, n),
                          239'(lat), 239'(lexp[s]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
